if_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. Holds the program counter, drives it into the external PC+4 `Adder` (in1 tied to 32'd4), and consumes the sum as the sequential next PC. It fetches from instruction memory over a req/ready handshake and loads the IF/ID pipeline register. Stall, flush and branch/jump redirect come from the hazard and EX stages.

---
 rtl/mips_pkg.sv | 13 +
 rtl/ifid_reg.sv | 55 +++++
 rtl/if_stage.sv | 128 ++++++++++++
 tb/tb_if_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: IF-stage state encoding and fetch constants.
package mips_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register holding {valid, instr, pc_plus4}.
// Ports: clk, rst (async active-high), load (capture instr_in/pc_plus4_in and
// set valid), clear (drop valid; contents kept), valid/instr/pc_plus4 outputs.
// load wins over clear.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_plus4
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

    // Next-value selection: load, clear or hold.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (load) begin
            valid_d    = 1'b1;
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
        end else if (clear) begin
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= DATA_WIDTH'(NOP_INSTR);
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM with one-entry skid buffer,
// and the IF/ID pipeline register.
// Ports: clk, rst (async active-high); pc_out -> external adder, pc_plus4_in
// <- adder sum; imem_req/imem_addr/imem_ready/imem_rdata fetch handshake;
// stall/flush/redirect_valid/redirect_target control; ifid_* outputs;
// misaligned_err sticky flag for redirect targets not word aligned.
module if_stage
    import mips_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] pc_out,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic                  ifid_valid,
    output logic [DATA_WIDTH-1:0] ifid_instr,
    output logic [DATA_WIDTH-1:0] ifid_pc_plus4,
    output logic                  misaligned_err
);

    if_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  err_q, err_d;

    logic                  ifid_load;
    logic                  ifid_clear;
    logic [DATA_WIDTH-1:0] ifid_instr_in;

    // Next-state, PC, skid buffer and IF/ID control.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_d        = skid_q;
        err_d         = err_q;
        ifid_load     = 1'b0;
        ifid_clear    = 1'b0;
        ifid_instr_in = imem_rdata;

        if (redirect_valid) begin
            pc_d       = {redirect_target[DATA_WIDTH-1:2], 2'b00};
            ifid_clear = 1'b1;
            state_d    = FETCH;
            if (redirect_target[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end else if (flush) begin
            // Skid contents are dropped by leaving HOLD; the PC is refetched.
            ifid_clear = 1'b1;
            state_d    = FETCH;
        end else begin
            unique case (state_q)
                RESET_WAIT: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        if (!stall) begin
                            ifid_load = 1'b1;
                            pc_d      = pc_plus4_in;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end else if (!stall) begin
                        ifid_clear = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load     = 1'b1;
                        ifid_instr_in = skid_q;
                        pc_d          = pc_plus4_in;
                        state_d       = FETCH;
                    end
                end
                default: begin
                    state_d = RESET_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_WAIT;
            pc_q    <= RESET_PC;
            skid_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
        end
    end

    ifid_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ifid_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .clear       (ifid_clear),
        .instr_in    (ifid_instr_in),
        .pc_plus4_in (pc_plus4_in),
        .valid       (ifid_valid),
        .instr       (ifid_instr),
        .pc_plus4    (ifid_pc_plus4)
    );

    // Request and address decode straight from registered state and PC.
    assign imem_req       = (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign pc_out         = pc_q;
    assign misaligned_err = err_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        misaligned_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the stage's architectural behaviour.
    logic [31:0] m_pc;
    bit          m_starting;   // first cycle after reset: no request yet
    bit          m_buffered;   // a fetched word waits for the stall to clear
    logic [31:0] m_buf;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    bit          m_err;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .pc_out          (pc_out),
        .pc_plus4_in     (pc_plus4_in),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .misaligned_err  (misaligned_err)
    );

    // External PC+4 adder.
    assign pc_plus4_in = pc_out + mips_pkg::PC_INCR;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_starting = 1'b1;
        m_buffered = 1'b0;
        m_buf      = 32'h0;
        m_valid    = 1'b0;
        m_instr    = 32'h0;
        m_pp4      = 32'h0;
        m_err      = 1'b0;
    endtask

    // One clock of the fetch rules, applied to the current inputs.
    task automatic model_update();
        if (redirect_valid) begin
            m_pc       = redirect_target & 32'hFFFF_FFFC;
            m_valid    = 1'b0;
            m_buffered = 1'b0;
            m_starting = 1'b0;
            if (redirect_target[1:0] != 2'b00) m_err = 1'b1;
        end else if (flush) begin
            m_valid    = 1'b0;
            m_buffered = 1'b0;
            m_starting = 1'b0;
        end else if (m_starting) begin
            m_starting = 1'b0;
        end else if (m_buffered) begin
            if (!stall) begin
                m_valid    = 1'b1;
                m_instr    = m_buf;
                m_pp4      = m_pc + 32'd4;
                m_pc       = m_pc + 32'd4;
                m_buffered = 1'b0;
            end
        end else if (imem_ready) begin
            if (!stall) begin
                m_valid = 1'b1;
                m_instr = imem_rdata;
                m_pp4   = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
            end else begin
                m_buf      = imem_rdata;
                m_buffered = 1'b1;
            end
        end else if (!stall) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        bit exp_req;
        exp_req = !m_starting && !m_buffered;
        check({tag, ".pc"}, pc_out, m_pc);
        check({tag, ".req"}, 32'(imem_req), 32'(exp_req));
        if (exp_req) check({tag, ".addr"}, imem_addr, m_pc);
        check({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
        if (m_valid) begin
            check({tag, ".instr"}, ifid_instr, m_instr);
            check({tag, ".pp4"}, ifid_pc_plus4, m_pp4);
        end
        check({tag, ".err"}, 32'(misaligned_err), 32'(m_err));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pc"}, pc_out, 32'h0);
        check({tag, ".req"}, 32'(imem_req), 32'h0);
        check({tag, ".valid"}, 32'(ifid_valid), 32'h0);
        check({tag, ".instr"}, ifid_instr, 32'h0);
        check({tag, ".pp4"}, ifid_pc_plus4, 32'h0);
        check({tag, ".err"}, 32'(misaligned_err), 32'h0);
    endtask

    // Called at a falling edge: apply inputs, clock once, check at next falling edge.
    task automatic step(input string tag, input logic rdy, input logic stl, input logic fl,
                        input logic rv, input logic [31:0] tgt, input logic [31:0] rd);
        imem_ready      = rdy;
        stall           = stl;
        flush           = fl;
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_rdata      = rd;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare(tag);
    endtask

    initial begin
        rst             = 1'b1;
        imem_ready      = 1'b0;
        imem_rdata      = 32'h0;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        model_reset();

        // Reset, then one cycle of RESET_WAIT before fetching.
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        compare("reset_wait");

        // Ready held high: sequential fetch of 0, 4, 8.
        step("leave_wait", 1, 0, 0, 0, 32'h0, 32'hAAAA_0000);
        step("seq0", 1, 0, 0, 0, 32'h0, 32'h1111_0000);
        check("seq0.pc_is_4", pc_out, 32'd4);
        step("seq1", 1, 0, 0, 0, 32'h0, 32'h1111_0004);
        check("seq1.pc_is_8", pc_out, 32'd8);

        // Ready + stall at PC=8: word buffered, PC held for three cycles.
        step("stall0", 1, 1, 0, 0, 32'h0, 32'h2222_0008);
        check("stall0.req_low", 32'(imem_req), 32'h0);
        step("stall1", 1, 1, 0, 0, 32'h0, 32'hDEAD_BEEF);
        step("stall2", 0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF);
        check("stall2.pc_is_8", pc_out, 32'd8);
        step("release", 0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF);
        check("release.instr", ifid_instr, 32'h2222_0008);
        check("release.pp4", ifid_pc_plus4, 32'd12);
        check("release.pc_is_12", pc_out, 32'd12);

        // Redirect while buffered in HOLD.
        step("hold_again", 1, 1, 0, 0, 32'h0, 32'h3333_000C);
        step("redir_hold", 1, 1, 0, 1, 32'h40, 32'h0);
        check("redir_hold.pc", pc_out, 32'h40);
        check("redir_hold.valid", 32'(ifid_valid), 32'h0);
        step("fetch_40", 1, 0, 0, 0, 32'h0, 32'h4444_0040);
        check("fetch_40.pp4", ifid_pc_plus4, 32'h44);

        // Flush refetches current PC; ready=0 gives a bubble.
        step("flush", 1, 0, 1, 0, 32'h0, 32'h5555_0000);
        step("bubble", 0, 0, 0, 0, 32'h0, 32'h0);
        step("refetch", 1, 0, 0, 0, 32'h0, 32'h6666_0044);

        // Misaligned target: aligned PC, sticky error.
        step("mis", 0, 0, 0, 1, 32'h42, 32'h0);
        check("mis.pc", pc_out, 32'h40);
        check("mis.err", 32'(misaligned_err), 32'h1);
        step("mis_after", 0, 0, 0, 1, 32'h80, 32'h0);
        check("mis_after.err", 32'(misaligned_err), 32'h1);

        // PC wrap at the top of the address space.
        step("to_top", 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
        step("wrap", 1, 0, 0, 0, 32'h0, 32'h7777_FFFC);
        check("wrap.pc", pc_out, 32'h0);
        check("wrap.pp4", ifid_pc_plus4, 32'h0);

        // Asynchronous reset mid-cycle while requesting with valid IF/ID.
        step("pre_rst", 1, 0, 0, 0, 32'h0, 32'h8888_0000);
        check("pre_rst.req", 32'(imem_req), 32'h1);
        check("pre_rst.valid", 32'(ifid_valid), 32'h1);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare("async_wait");
        step("async_leave", 1, 0, 0, 0, 32'h0, 32'h9999_0000);
        step("async_fetch", 1, 0, 0, 0, 32'h0, 32'h9999_0004);
        check("async_fetch.pp4", ifid_pc_plus4, 32'd4);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        rdy, stl, fl, rv;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 2) != 0);
            stl = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
            step("rand", rdy, stl, fl, rv, tgt, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
